rib_arbiter: RTL and testbench

Registered arbiter for the shared RIB bus across its four masters: core data (m0), pc fetch (m1), jtag (m2) and uart_debug (m3).
- Holds a grant across multi-cycle slave accesses; the i2c slave is the multi-cycle case, paced by its ready.
- Supports fixed-priority and round-robin modes.
- Promotes starved requesters by aging.
- Times out hung transactions.
- Drives the select for the rib datapath muxes and the pipeline hold flag to the active core.

---
 rtl/rib_arb_defs_pkg.sv | 38 +++
 rtl/rib_arb_pick.sv | 36 +++
 rtl/rib_arbiter.sv | 130 +++++++++++++
 tb/tb_rib_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rib_arb_defs_pkg.sv
// Shared constants and types for the RIB bus arbiter: master indices, fixed
// priority table, FSM encoding and counter-width helpers.
package rib_arb_defs;

    localparam int NUM_M = 4;

    typedef logic [1:0] midx_t;

    localparam midx_t M_CORE = 2'd0;
    localparam midx_t M_PC   = 2'd1;
    localparam midx_t M_JTAG = 2'd2;
    localparam midx_t M_UART = 2'd3;

    // Entry 0 is the highest priority: m3 > m0 > m2 > m1.
    localparam logic [NUM_M-1:0][1:0] FIXED_ORDER = {M_PC, M_JTAG, M_CORE, M_UART};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MAX_WAIT_DEF = 15;
    localparam int TIMEOUT_DEF  = 255;

    function automatic int cnt_w(input int maxv);
        return (maxv < 2) ? 1 : $clog2(maxv + 1);
    endfunction

    function automatic midx_t onehot2idx(input logic [NUM_M-1:0] v);
        midx_t r;
        r = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (v[i]) r = r | midx_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rib_arb_pick.sv
// Combinational winner selection: aged requesters first, then fixed-priority
// or round-robin ordering among the surviving candidates.
module rib_arb_pick
    import rib_arb_defs::*;
(
    input  logic [NUM_M-1:0] req,
    input  logic [NUM_M-1:0] aged,
    input  logic [NUM_M-1:0] excl,
    input  logic             mode,
    input  midx_t            rr_ptr,
    output logic [NUM_M-1:0] win,
    output logic             win_valid
);

    logic [NUM_M-1:0] eff;
    logic [NUM_M-1:0] cand;
    midx_t            idx;

    always_comb begin
        eff       = req & ~excl;
        cand      = (|(eff & aged)) ? (eff & aged) : eff;
        win       = '0;
        idx       = '0;
        win_valid = |cand;
        // Walk from lowest to highest precedence so the last hit wins.
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (mode) idx = rr_ptr + midx_t'(i);
            else      idx = FIXED_ORDER[i];
            if (cand[idx]) begin
                win      = '0;
                win[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// Registered arbiter for the shared RIB bus with grant hold across multi-cycle
// slave accesses, aging of starved masters and hung-access timeout.
module rib_arbiter
    import rib_arb_defs::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_i,
    input  logic [NUM_M-1:0] req_i,
    input  logic             slave_ready_i,
    output logic [NUM_M-1:0] grant_o,
    output logic [1:0]       grant_idx_o,
    output logic             grant_valid_o,
    output logic             hold_flag_o,
    output logic             timeout_o
);

    localparam int WW = cnt_w(MAX_WAIT);
    localparam int TW = cnt_w(TIMEOUT);

    state_t                     state_q, state_d;
    logic [NUM_M-1:0]           grant_q, grant_d;
    midx_t                      rr_q, rr_d;
    logic [TW-1:0]              to_q, to_d;
    logic                       timeout_q, timeout_d;
    logic                       hold_q, hold_d;
    logic [NUM_M-1:0][WW-1:0]   wait_q;
    logic [NUM_M-1:0]           aged;

    midx_t            g_idx;
    logic             req_g, complete, drop, to_hit;
    logic [NUM_M-1:0] excl, win;
    logic             win_valid;

    assign g_idx    = onehot2idx(grant_q);
    assign req_g    = |(req_i & grant_q);
    assign complete = (state_q == BUSY) && req_g && slave_ready_i;
    assign drop     = (state_q == BUSY) && !req_g;
    assign to_hit   = (state_q == BUSY) && !complete && !drop && (to_q == TW'(TIMEOUT - 1));
    // The finishing or timed-out master steps aside so others get the bus.
    assign excl     = (complete || to_hit) ? grant_q : '0;

    rib_arb_pick u_pick (
        .req       (req_i),
        .aged      (aged),
        .excl      (excl),
        .mode      (mode_i),
        .rr_ptr    (rr_q),
        .win       (win),
        .win_valid (win_valid)
    );

    for (genvar n = 0; n < NUM_M; n++) begin : g_wait
        always_ff @(posedge clk) begin
            if (rst)                           wait_q[n] <= '0;
            else if (!req_i[n] || grant_q[n])  wait_q[n] <= '0;
            else if (wait_q[n] != WW'(MAX_WAIT)) wait_q[n] <= wait_q[n] + WW'(1);
        end
        assign aged[n] = (wait_q[n] == WW'(MAX_WAIT));
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        to_d      = to_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                to_d = '0;
                if (win_valid) begin
                    grant_d = win;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (complete) begin
                    // Requester still asserts req, so a lone master is re-granted.
                    grant_d = win_valid ? win : grant_q;
                    to_d    = '0;
                    rr_d    = g_idx + midx_t'(1);
                end else if (drop || to_hit) begin
                    timeout_d = to_hit;
                    to_d      = '0;
                    if (win_valid) begin
                        grant_d = win;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        hold_d = (|grant_d) && (grant_d != (NUM_M'(1) << M_PC));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            to_q      <= '0;
            timeout_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            to_q      <= to_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = g_idx;
    assign grant_valid_o = |grant_q;
    assign hold_flag_o   = hold_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: expected grants are queued as stimulus is
// applied and popped when the DUT presents each grant.
module tb_rib_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_i;
    logic [3:0] req_i;
    logic       slave_ready_i;
    logic [3:0] grant_o;
    logic [1:0] grant_idx_o;
    logic       grant_valid_o;
    logic       hold_flag_o;
    logic       timeout_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] idx;
        logic       hold;
    } exp_t;

    exp_t exp_q[$];

    rib_arbiter #(.MAX_WAIT(3), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_i        (mode_i),
        .req_i         (req_i),
        .slave_ready_i (slave_ready_i),
        .grant_o       (grant_o),
        .grant_idx_o   (grant_idx_o),
        .grant_valid_o (grant_valid_o),
        .hold_flag_o   (hold_flag_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] idx, input logic hold);
        exp_t e;
        e.idx  = idx;
        e.hold = hold;
        exp_q.push_back(e);
    endtask

    task automatic chk_grant(input string tag, output logic [1:0] idx);
        exp_t e;
        idx = '0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got idx %0d", tag, grant_idx_o);
        end else begin
            e   = exp_q.pop_front();
            idx = e.idx;
            chk({tag, "_idx"},   32'(grant_idx_o),   32'(e.idx));
            chk({tag, "_oh"},    32'(grant_o),       32'(4'b0001 << e.idx));
            chk({tag, "_valid"}, 32'(grant_valid_o), 32'(1));
            chk({tag, "_hold"},  32'(hold_flag_o),   32'(e.hold));
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req_i         = '0;
        slave_ready_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant_o),       32'(0));
        chk({tag, "_valid"}, 32'(grant_valid_o), 32'(0));
        chk({tag, "_hold"},  32'(hold_flag_o),   32'(0));
        chk({tag, "_to"},    32'(timeout_o),     32'(0));
    endtask

    initial begin
        logic [1:0] g;
        int         prev;

        rst = 1'b1; mode_i = 1'b0; req_i = '0; slave_ready_i = 1'b0;
        step(); step();
        chk_idle("reset");
        chk("reset_idx", 32'(grant_idx_o), 32'(0));
        rst = 1'b0;

        // Fixed priority, each master retires its request after one completion.
        mode_i = 1'b0; slave_ready_i = 1'b1; req_i = 4'b1111;
        push(2'd3, 1'b1); push(2'd0, 1'b1); push(2'd2, 1'b1); push(2'd1, 1'b0);
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (prev >= 0) req_i[prev] = 1'b0;
            chk_grant("fixed", g);
            prev = int'(g);
        end

        // Round-robin alternation between m0 and m2.
        do_reset();
        mode_i = 1'b1; slave_ready_i = 1'b1; req_i = 4'b0101;
        push(2'd0, 1'b1); push(2'd2, 1'b1); push(2'd0, 1'b1); push(2'd2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_grant("rr", g);
            if (k == 1) chk("rr_ptr", 32'(dut.rr_q), 32'(1));
        end

        // Multi-cycle slave: grant held on m0 while m3 waits.
        do_reset();
        mode_i = 1'b0; req_i = 4'b0001;
        push(2'd0, 1'b1);
        step();
        chk_grant("mc_first", g);
        req_i = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            push(2'd0, 1'b1);
            step();
            chk_grant("mc_hold", g);
            chk("mc_to", 32'(timeout_o), 32'(0));
        end
        slave_ready_i = 1'b1;
        push(2'd3, 1'b1);
        step();
        chk_grant("mc_move", g);

        // Timeout: m2 never sees ready, m1 pending.
        do_reset();
        mode_i = 1'b0; req_i = 4'b0100;
        push(2'd2, 1'b1);
        step();
        chk_grant("to_first", g);
        req_i = 4'b0110;
        for (int c = 1; c < 8; c++) begin
            step();
            chk("to_quiet", 32'(timeout_o), 32'(0));
            chk("to_held",  32'(grant_idx_o), 32'(2));
        end
        push(2'd1, 1'b0);
        step();
        chk("to_pulse", 32'(timeout_o), 32'(1));
        chk_grant("to_move", g);
        step();
        chk("to_once", 32'(timeout_o), 32'(0));
        chk("to_keep", 32'(grant_idx_o), 32'(1));

        // Aging: m1 starved by m3/m0 until its wait counter saturates.
        do_reset();
        mode_i = 1'b0; slave_ready_i = 1'b1; req_i = 4'b1011;
        push(2'd3, 1'b1); push(2'd0, 1'b1); push(2'd3, 1'b1); push(2'd1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_grant("age", g);
        end

        // Reset mid-access near the timeout threshold.
        do_reset();
        mode_i = 1'b0; req_i = 4'b0001;
        push(2'd0, 1'b1);
        step();
        chk_grant("rst_first", g);
        for (int k = 0; k < 6; k++) step();
        rst = 1'b1; req_i = '0;
        step();
        chk_idle("rst_now");
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            chk_idle("rst_after");
        end
        req_i = 4'b0001;
        push(2'd0, 1'b1);
        step();
        chk_grant("rst_fresh", g);

        chk("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
